// File: rtl/load_store_unit.sv
`timescale 1ns / 1ps
// load_store_unit: CPU-side initiator for a word-addressed data memory.
// Takes RV32I load/store requests with byte addresses and turns them into
// word-indexed read/write strobes. Sub-word stores are done as a
// read-modify-write. Loads are sign- or zero-extended.
//
// Optional feature: define LSU_BOUNDS_CHECK_EN to flag any request whose
// word index is >= MEM_WORDS as an error.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_funct3            RV32I width/sign code
//   req_addr, req_wdata   byte address, right-aligned store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_error            misaligned, illegal funct3 or out of range
//   mem_addr              word index {2'b00, byte_addr[31:2]}
//   mem_write_data        full word to write
//   mem_memwrite          write strobe
//   mem_memread           read strobe
//   mem_read_data         combinational memory read word
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        err_q;
  logic [15:0] wdata_lo_q;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        f3_legal, misaligned, range_err, req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext, merged;

  // Request decode, evaluated on the live inputs at accept time.
  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~req_we;
      default:                f3_legal = 1'b0;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

`ifdef LSU_BOUNDS_CHECK_EN
  assign range_err = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
`else
  logic unused_mem_words;
  assign unused_mem_words = ^MEM_WORDS;
  assign range_err = 1'b0;
`endif

  assign req_err = ~f3_legal | misaligned | range_err;

  // Lane extraction and extension for loads, lane merge for sub-word stores.
  always_comb begin
    case (off_q)
      2'd0:    lane_byte = mem_read_data[7:0];
      2'd1:    lane_byte = mem_read_data[15:8];
      2'd2:    lane_byte = mem_read_data[23:16];
      default: lane_byte = mem_read_data[31:24];
    endcase
    lane_half = off_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    case (funct3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'h0, lane_byte};
      3'b101:  load_ext = {16'h0, lane_half};
      default: load_ext = mem_read_data;
    endcase

    merged = mem_read_data;
    if (!funct3_q[0]) begin
      case (off_q)
        2'd0:    merged[7:0]   = wdata_lo_q[7:0];
        2'd1:    merged[15:8]  = wdata_lo_q[7:0];
        2'd2:    merged[23:16] = wdata_lo_q[7:0];
        default: merged[31:24] = wdata_lo_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = wdata_lo_q;
    end else begin
      merged[15:0] = wdata_lo_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = StResp;
            rdata_d = 32'h0;
          end else begin
            mem_addr_d = {2'b00, req_addr[31:2]};
            if (req_we && (req_funct3 == 3'b010)) begin
              state_d     = StWrite;
              mem_wdata_d = req_wdata;
            end else begin
              state_d = StRead;
            end
          end
        end
      end
      StRead: begin
        if (we_q) begin
          state_d     = StWrite;
          mem_wdata_d = merged;
        end else begin
          state_d = StResp;
          rdata_d = load_ext;
        end
      end
      StWrite: begin
        state_d = StResp;
        rdata_d = 32'h0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      wdata_lo_q  <= 16'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      if ((state_q == StIdle) && req_valid) begin
        off_q      <= req_addr[1:0];
        funct3_q   <= req_funct3;
        we_q       <= req_we;
        err_q      <= req_err;
        wdata_lo_q <= req_wdata[15:0];
      end
    end
  end

  // Gated by rst_n so every output reads 0 while reset is held.
  assign req_ready      = (state_q == StIdle) & rst_n;
  assign resp_valid     = (state_q == StResp);
  assign resp_error     = (state_q == StResp) & err_q;
  assign resp_rdata     = rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_memread    = (state_q == StRead);
  assign mem_memwrite   = (state_q == StWrite);

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns / 1ps
// Self-checking bench for load_store_unit: a behavioural memory, a response
// scoreboard fed at request time and drained by a monitor, directed cases
// and a short random run checked against a small reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(8192)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_read_data  (mem_read_data)
  );

  // Memory: combinational read, write on clock while strobe is high.
  // Backdoor pokes share the single writing process.
  bit   [31:0] mem [0:8191];
  logic        bd_valid = 1'b0;
  logic [12:0] bd_idx;
  logic [31:0] bd_data;

  assign mem_read_data = mem[mem_addr[12:0]];

  always @(posedge clk) begin
    if (mem_memwrite) mem[mem_addr[12:0]] <= mem_write_data;
    else if (bd_valid) mem[bd_idx] <= bd_data;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    rd_cnt = 0;
  int    wr_cnt = 0;
  logic [31:0] wr_data_seen = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: strobe bookkeeping and scoreboard drain.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_memread) rd_cnt++;
        if (mem_memwrite) begin
          wr_cnt++;
          wr_data_seen = mem_write_data;
        end
        if (mem_memread || mem_memwrite)
          check_eq("strobe_excl", 32'(mem_memread & mem_memwrite), 32'h0);
        if (resp_valid) begin
          if (sb_q.size() == 0) begin
            check_eq("unexp_resp", 32'(resp_valid), 32'h0);
          end else begin
            e = sb_q.pop_front();
            check_eq("resp_rdata", resp_rdata, e.rdata);
            check_eq("resp_error", 32'(resp_error), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_idx = 13'(idx);
    bd_data = data;
    bd_valid = 1'b1;
    @(posedge clk);
    #1 bd_valid = 1'b0;
  endtask

  // Reference model, written as shift/mask arithmetic.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] word,
                       output logic [31:0] rdata, output logic err,
                       output logic [31:0] nword);
    logic [31:0] v, mask;
    int sh;
    err = 1'b1;
    if (!we && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) err = 1'b0;
    if (we && (f3 inside {3'd0, 3'd1, 3'd2})) err = 1'b0;
    if (f3[1:0] == 2'd1 && addr[0]) err = 1'b1;
    if (f3[1:0] == 2'd2 && addr[1:0] != 2'd0) err = 1'b1;
`ifdef LSU_BOUNDS_CHECK_EN
    if ({2'b00, addr[31:2]} >= 32'd8192) err = 1'b1;
`endif
    sh = 8 * int'(addr[1:0]);
    v = word >> sh;
    rdata = 32'h0;
    nword = word;
    if (!err && !we) begin
      case (f3)
        3'd0: rdata = {{24{v[7]}}, v[7:0]};
        3'd1: rdata = {{16{v[15]}}, v[15:0]};
        3'd4: rdata = {24'h0, v[7:0]};
        3'd5: rdata = {16'h0, v[15:0]};
        default: rdata = word;
      endcase
    end else if (!err) begin
      mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      mask = mask << sh;
      nword = (word & ~mask) | ((wdata << sh) & mask);
    end
  endtask

  // One full transaction with latency, strobe and memory-effect checks.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input logic [31:0] exp_word);
    int lat, cyc, rd0, wr0, exp_rd, exp_wr;
    lat    = exp_err ? 1 : (!we || f3 == 3'd2) ? 2 : 3;
    exp_rd = (!exp_err && (!we || f3 != 3'd2)) ? 1 : 0;
    exp_wr = (!exp_err && we) ? 1 : 0;
    @(negedge clk);
    check_eq("req_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(posedge clk);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    // Scramble the request bus to prove the unit latched it.
    #1 req_valid = 1'b0;
    req_we = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && exp_rd == 1) begin
        check_eq("first_memread", 32'(mem_memread), 32'h1);
        check_eq("first_mem_addr", mem_addr, {2'b00, addr[31:2]});
      end
    end while (!resp_valid && cyc < 8);
    check_eq("latency", 32'(cyc), 32'(lat));
    #1;
    check_eq("read_strobes", 32'(rd_cnt - rd0), 32'(exp_rd));
    check_eq("write_strobes", 32'(wr_cnt - wr0), 32'(exp_wr));
    if (exp_wr == 1) check_eq("write_data", wr_data_seen, exp_word);
    @(negedge clk);
    check_eq("resp_pulse", 32'(resp_valid), 32'h0);
    check_eq("rdata_hold", resp_rdata, exp_rdata);
    check_eq("ready_after", 32'(req_ready), 32'h1);
    if (!exp_err) check_eq("mem_word", mem[addr[14:2]], exp_word);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, nw, a, wd;
    logic e, we;
    logic [2:0] f3;
    logic [1:0] lo;
    int idx;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_strobes", 32'({mem_memread, mem_memwrite}), 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_wdata", mem_write_data, 32'h0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    #1 check_eq("rel_req_ready", 32'(req_ready), 32'h1);

    poke(4, 32'hDEADBEEF);
    poke(5, 32'h11223344);
    poke(8, 32'hCAFEF00D);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);

    poke(4, 32'h8070F0A1);
    issue(1'b0, 3'd0, 32'h11, 32'h0, 32'hFFFFFFF0, 1'b0, 32'h8070F0A1);
    issue(1'b0, 3'd4, 32'h11, 32'h0, 32'h000000F0, 1'b0, 32'h8070F0A1);
    issue(1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF8070, 1'b0, 32'h8070F0A1);
    issue(1'b0, 3'd5, 32'h12, 32'h0, 32'h00008070, 1'b0, 32'h8070F0A1);

    issue(1'b1, 3'd0, 32'h16, 32'h000000AA, 32'h0, 1'b0, 32'h11AA3344);
    issue(1'b1, 3'd1, 32'h10, 32'h12345678, 32'h0, 1'b0, 32'h80705678);
    issue(1'b1, 3'd2, 32'h14, 32'hA5A5_5A5A, 32'h0, 1'b0, 32'hA5A5_5A5A);

    issue(1'b1, 3'd2, 32'h22, 32'h1, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 3'd1, 32'h13, 32'h0, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 3'd4, 32'h10, 32'h0, 32'h0, 1'b1, 32'h0);

    // Reset during the READ of an SH: no write, no response.
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'd1;
    req_addr = 32'h22;
    req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_in_read", 32'(mem_memread), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_strobes", 32'({mem_memread, mem_memwrite}), 32'h0);
    check_eq("mid_resp", 32'(resp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_quiet", 32'({resp_valid, mem_memwrite}), 32'h0);
    end
    check_eq("post_rst_ready", 32'(req_ready), 32'h1);
    check_eq("post_rst_mem", mem[8], 32'hCAFEF00D);

`ifdef LSU_BOUNDS_CHECK_EN
    poke(8191, 32'h0BADF00D);
    issue(1'b0, 3'd2, 32'h0000_8000, 32'h0, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 3'd2, 32'h0000_7FFC, 32'h0, 32'h0BADF00D, 1'b0, 32'h0BADF00D);
`endif

    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom);
      f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      idx = $urandom_range(0, 15);
      lo = 2'($urandom);
      a = {18'h0, 12'(idx), lo};
      wd = $urandom;
      model(we, f3, a, wd, mem[idx], r, e, nw);
      issue(we, f3, a, wd, r, e, nw);
    end

    repeat (2) @(negedge clk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
